// File: rtl/parking_lot_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : parking_lot_pkg
// Description : Shared types, constants and helper functions for the parking
//               lot request path (request kinds, plate/floor widths, plate
//               validation).
// Revision    : 1.0 - initial release
// ============================================================================
package parking_lot_pkg;

    localparam int PLATE_W    = 16;
    localparam int FLOOR_W    = 3;
    localparam int NUM_FLOORS = 7;

    // Job kind carried alongside each queued plate
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_IN   = 2'd1,
        REQ_OUT  = 2'd2,
        REQ_LEAK = 2'd3
    } req_kind_e;

    // A plate is usable when every BCD digit is 0..9 and it is not all zeros
    function automatic logic plate_valid(input logic [PLATE_W-1:0] plate);
        logic ok;
        ok = (plate != '0);
        for (int i = 0; i < PLATE_W / 4; i++) begin
            if (plate[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage : parking_lot_pkg
`default_nettype wire

// File: rtl/parking_req_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : parking_req_fifo
// Description : Parameterised synchronous FIFO with push/pop, full/empty and
//               occupancy count. A push while full is accepted only when a
//               pop frees the head slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Qualify handshakes and compute next pointers, occupancy and storage
    always_comb begin
        do_pop   = pop  && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are qualified by the occupancy so no reset needed
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule : parking_req_fifo
`default_nettype wire

// File: rtl/parking_request_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : parking_request_queue
// Description : Request intake for the parking lot. Registers gate and leak
//               inputs, validates plates, queues park/retrieve jobs in a FIFO,
//               holds the latest leak in a priority slot and presents one job
//               at a time to the elevator controller.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_request_queue #(
    parameter int DEPTH   = 8,
    parameter int PLATE_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PLATE_W-1:0]       license_plate,
    input  logic                     in_mode,
    input  logic                     out_mode,
    input  logic                     leakage,
    input  logic [2:0]               leakage_floor,
    input  logic                     todo_pop,
    output logic                     todo_exists,
    output logic                     todo_in,
    output logic                     todo_out,
    output logic                     todo_leak_move,
    output logic [PLATE_W-1:0]       todo_license_plate,
    output logic [2:0]               todo_leak_floor,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     req_error,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    import parking_lot_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 + PLATE_W;

    // Input sample stage
    logic               in_s_q,     in_s_d;
    logic               out_s_q,    out_s_d;
    logic [PLATE_W-1:0] plate_s_q,  plate_s_d;
    logic               leak_s_q,   leak_s_d;
    logic [FLOOR_W-1:0] floor_s_q,  floor_s_d;
    logic               leak_prev_q,  leak_prev_d;
    logic [FLOOR_W-1:0] floor_prev_q, floor_prev_d;

    // Leak slot and status
    logic               leak_valid_q, leak_valid_d;
    logic [FLOOR_W-1:0] leak_floor_q, leak_floor_d;
    logic               req_error_q,  req_error_d;
    logic               overflow_q,   overflow_d;
    logic [7:0]         drop_cnt_q,   drop_cnt_d;

    // Decode of the sampled request
    logic               gate_req;
    logic               bad_req;
    logic               push_req;
    logic               leak_event;
    logic               ovf_now;
    logic [EW-1:0]      push_entry;

    // FIFO interface
    logic               fifo_pop;
    logic [EW-1:0]      fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [1:0]         head_kind;

    parking_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Capture raw inputs; the previous leak sample feeds edge/change detection
    always_comb begin
        in_s_d       = in_mode;
        out_s_d      = out_mode;
        plate_s_d    = license_plate;
        leak_s_d     = leakage;
        floor_s_d    = leakage_floor;
        leak_prev_d  = leak_s_q;
        floor_prev_d = floor_s_q;
    end

    // Validate the sampled request, detect leak events and arbitrate pops
    always_comb begin
        gate_req   = in_s_q | out_s_q;
        bad_req    = gate_req && ((in_s_q && out_s_q) || !plate_valid(plate_s_q));
        push_req   = gate_req && !bad_req;
        push_entry = {(in_s_q ? REQ_IN : REQ_OUT), plate_s_q};
        leak_event = leak_s_q && (floor_s_q != '0)
                     && (!leak_prev_q || (floor_s_q != floor_prev_q));
        // FIFO head is only poppable while no leak job shadows it
        fifo_pop   = todo_pop && !leak_valid_q && !fifo_empty;
        ovf_now    = push_req && fifo_full && !fifo_pop;
    end

    // Next state for leak slot and error bookkeeping
    always_comb begin
        leak_valid_d = leak_valid_q;
        leak_floor_d = leak_floor_q;
        if (todo_pop && leak_valid_q) begin
            leak_valid_d = 1'b0;
            leak_floor_d = '0;
        end
        // A load in the pop cycle wins so the newer leak stays pending
        if (leak_event) begin
            leak_valid_d = 1'b1;
            leak_floor_d = floor_s_q;
        end
        req_error_d = bad_req;
        overflow_d  = overflow_q | ovf_now;
        drop_cnt_d  = drop_cnt_q;
        if ((bad_req || ovf_now) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            in_s_q       <= 1'b0;
            out_s_q      <= 1'b0;
            plate_s_q    <= '0;
            leak_s_q     <= 1'b0;
            floor_s_q    <= '0;
            leak_prev_q  <= 1'b0;
            floor_prev_q <= '0;
            leak_valid_q <= 1'b0;
            leak_floor_q <= '0;
            req_error_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            in_s_q       <= in_s_d;
            out_s_q      <= out_s_d;
            plate_s_q    <= plate_s_d;
            leak_s_q     <= leak_s_d;
            floor_s_q    <= floor_s_d;
            leak_prev_q  <= leak_prev_d;
            floor_prev_q <= floor_prev_d;
            leak_valid_q <= leak_valid_d;
            leak_floor_q <= leak_floor_d;
            req_error_q  <= req_error_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Present the current job: leak slot first, then the FIFO head
    always_comb begin
        head_kind          = fifo_rdata[EW-1 -: 2];
        todo_exists        = leak_valid_q || !fifo_empty;
        todo_leak_move     = leak_valid_q;
        todo_in            = !leak_valid_q && !fifo_empty && (head_kind == REQ_IN);
        todo_out           = !leak_valid_q && !fifo_empty && (head_kind == REQ_OUT);
        todo_leak_floor    = leak_valid_q ? leak_floor_q : '0;
        todo_license_plate = (!leak_valid_q && !fifo_empty) ? fifo_rdata[PLATE_W-1:0] : '0;
    end

    assign count     = fifo_count;
    assign full      = fifo_full;
    assign req_error = req_error_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule : parking_request_queue
`default_nettype wire

// File: tb/tb_parking_request_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_parking_request_queue
// Description : Directed self-checking bench for parking_request_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_request_queue;

    logic        clock;
    logic        reset;
    logic [15:0] license_plate;
    logic        in_mode;
    logic        out_mode;
    logic        leakage;
    logic [2:0]  leakage_floor;
    logic        todo_pop;
    logic        todo_exists;
    logic        todo_in;
    logic        todo_out;
    logic        todo_leak_move;
    logic [15:0] todo_license_plate;
    logic [2:0]  todo_leak_floor;
    logic [3:0]  count;
    logic        full;
    logic        req_error;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_checks;
    int n_fail;

    parking_request_queue #(.DEPTH(8), .PLATE_W(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .license_plate      (license_plate),
        .in_mode            (in_mode),
        .out_mode           (out_mode),
        .leakage            (leakage),
        .leakage_floor      (leakage_floor),
        .todo_pop           (todo_pop),
        .todo_exists        (todo_exists),
        .todo_in            (todo_in),
        .todo_out           (todo_out),
        .todo_leak_move     (todo_leak_move),
        .todo_license_plate (todo_license_plate),
        .todo_leak_floor    (todo_leak_floor),
        .count              (count),
        .full               (full),
        .req_error          (req_error),
        .overflow           (overflow),
        .drop_cnt           (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        in_mode       = 1'b0;
        out_mode      = 1'b0;
        license_plate = '0;
        leakage       = 1'b0;
        leakage_floor = '0;
        todo_pop      = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // One-cycle gate pulse
    task automatic gate(input logic im, input logic om, input logic [15:0] plate);
        in_mode       = im;
        out_mode      = om;
        license_plate = plate;
        tick();
        in_mode       = 1'b0;
        out_mode      = 1'b0;
        license_plate = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({todo_exists, todo_in, todo_out, todo_leak_move} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {todo_exists, todo_in, todo_out, todo_leak_move});
        end
        n_checks++;
        if ({todo_license_plate, todo_leak_floor, count, full, req_error, overflow, drop_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_data: plate %h floor %0d count %0d full %b err %b ovf %b drop %0d want all 0",
                todo_license_plate, todo_leak_floor, count, full, req_error, overflow, drop_cnt);
        end
    endtask

    task automatic test_single_park();
        do_reset();
        gate(1'b1, 1'b0, 16'h9423);
        n_checks++;
        if (todo_exists !== 1'b0) begin
            n_fail++; $display("FAIL single_latency: todo_exists got %b want 0 one edge after sample", todo_exists);
        end
        tick();
        n_checks++;
        if ({todo_exists, todo_in, todo_out, todo_license_plate, count} !== {1'b1, 1'b1, 1'b0, 16'h9423, 4'd1}) begin
            n_fail++; $display("FAIL single_present: exists %b in %b out %b plate %h count %0d want 1 1 0 9423 1",
                todo_exists, todo_in, todo_out, todo_license_plate, count);
        end
        todo_pop = 1'b1;
        tick();
        todo_pop = 1'b0;
        n_checks++;
        if ({todo_exists, count} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL single_pop: exists %b count %0d want 0 0", todo_exists, count);
        end
        // Pop while nothing presented must be harmless
        todo_pop = 1'b1;
        tick();
        todo_pop = 1'b0;
        gate(1'b0, 1'b1, 16'h4321);
        tick();
        n_checks++;
        if ({todo_exists, todo_in, todo_out, todo_license_plate, count} !== {1'b1, 1'b0, 1'b1, 16'h4321, 4'd1}) begin
            n_fail++; $display("FAIL single_retrieve: exists %b in %b out %b plate %h count %0d want 1 0 1 4321 1",
                todo_exists, todo_in, todo_out, todo_license_plate, count);
        end
    endtask

    task automatic test_burst();
        logic [15:0] plates [4];
        plates[0] = 16'h9522; plates[1] = 16'h9532; plates[2] = 16'h1755; plates[3] = 16'h5752;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            gate(1'b1, 1'b0, plates[i]);
            tick();
        end
        n_checks++;
        if (count !== 4'd4) begin
            n_fail++; $display("FAIL burst_count: got %0d want 4", count);
        end
        todo_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({todo_exists, todo_in, todo_license_plate} !== {1'b1, 1'b1, plates[i]}) begin
                n_fail++; $display("FAIL burst_order%0d: exists %b in %b plate %h want 1 1 %h",
                    i, todo_exists, todo_in, todo_license_plate, plates[i]);
            end
            tick();
        end
        todo_pop = 1'b0;
        n_checks++;
        if ({todo_exists, count} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL burst_drain: exists %b count %0d want 0 0", todo_exists, count);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        gate(1'b1, 1'b1, 16'h8754);
        tick();
        n_checks++;
        if ({req_error, drop_cnt, count, overflow} !== {1'b1, 8'd1, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL inv_both: err %b drop %0d count %0d ovf %b want 1 1 0 0", req_error, drop_cnt, count, overflow);
        end
        tick();
        n_checks++;
        if (req_error !== 1'b0) begin
            n_fail++; $display("FAIL inv_pulse_width: err got %b want 0", req_error);
        end
        gate(1'b1, 1'b0, 16'h9A23);
        tick();
        n_checks++;
        if ({req_error, drop_cnt, count} !== {1'b1, 8'd2, 4'd0}) begin
            n_fail++; $display("FAIL inv_bcd: err %b drop %0d count %0d want 1 2 0", req_error, drop_cnt, count);
        end
        gate(1'b0, 1'b1, 16'h0000);
        tick();
        n_checks++;
        if ({req_error, drop_cnt, count, todo_exists} !== {1'b1, 8'd3, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL inv_zero: err %b drop %0d count %0d exists %b want 1 3 0 0",
                req_error, drop_cnt, count, todo_exists);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        in_mode = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            license_plate = 16'h1000 + 16'(i);
            tick();
            if (i == 9) begin
                n_checks++;
                if ({full, count, overflow} !== {1'b1, 4'd8, 1'b0}) begin
                    n_fail++; $display("FAIL ovf_full_at8: full %b count %0d ovf %b want 1 8 0", full, count, overflow);
                end
            end
        end
        in_mode = 1'b0;
        license_plate = '0;
        tick();
        n_checks++;
        if ({overflow, drop_cnt, count, req_error} !== {1'b1, 8'd1, 4'd8, 1'b0}) begin
            n_fail++; $display("FAIL ovf_drop: ovf %b drop %0d count %0d err %b want 1 1 8 0",
                overflow, drop_cnt, count, req_error);
        end
        gate(1'b1, 1'b0, 16'h2222);
        todo_pop = 1'b1;
        tick();
        todo_pop = 1'b0;
        n_checks++;
        if ({count, full, drop_cnt, todo_license_plate} !== {4'd8, 1'b1, 8'd1, 16'h1002}) begin
            n_fail++; $display("FAIL ovf_push_pop: count %0d full %b drop %0d head %h want 8 1 1 1002",
                count, full, drop_cnt, todo_license_plate);
        end
    endtask

    task automatic test_leak_priority();
        do_reset();
        gate(1'b1, 1'b0, 16'h1111);
        gate(1'b1, 1'b0, 16'h2222);
        gate(1'b1, 1'b0, 16'h3333);
        leakage = 1'b1;
        leakage_floor = 3'd4;
        tick();
        tick();
        n_checks++;
        if ({todo_exists, todo_leak_move, todo_in, todo_leak_floor, todo_license_plate, count}
            !== {1'b1, 1'b1, 1'b0, 3'd4, 16'h0000, 4'd3}) begin
            n_fail++; $display("FAIL leak_present: exists %b leak %b in %b floor %0d plate %h count %0d want 1 1 0 4 0000 3",
                todo_exists, todo_leak_move, todo_in, todo_leak_floor, todo_license_plate, count);
        end
        todo_pop = 1'b1;
        tick();
        todo_pop = 1'b0;
        n_checks++;
        if ({todo_leak_move, todo_in, todo_leak_floor, todo_license_plate, count}
            !== {1'b0, 1'b1, 3'd0, 16'h1111, 4'd3}) begin
            n_fail++; $display("FAIL leak_resume: leak %b in %b floor %0d plate %h count %0d want 0 1 0 1111 3",
                todo_leak_move, todo_in, todo_leak_floor, todo_license_plate, count);
        end
        leakage_floor = 3'd0;
        tick();
        tick();
        n_checks++;
        if ({todo_leak_move, todo_license_plate} !== {1'b0, 16'h1111}) begin
            n_fail++; $display("FAIL leak_floor0: leak %b plate %h want 0 1111", todo_leak_move, todo_license_plate);
        end
        leakage_floor = 3'd6;
        tick();
        tick();
        n_checks++;
        if ({todo_leak_move, todo_leak_floor} !== {1'b1, 3'd6}) begin
            n_fail++; $display("FAIL leak_change: leak %b floor %0d want 1 6", todo_leak_move, todo_leak_floor);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            license_plate = 16'h5000 + 16'(i);
            tick();
        end
        in_mode = 1'b0;
        license_plate = '0;
        leakage = 1'b1;
        leakage_floor = 3'd2;
        tick();
        tick();
        n_checks++;
        if ({count, todo_leak_move, todo_leak_floor} !== {4'd5, 1'b1, 3'd2}) begin
            n_fail++; $display("FAIL mid_setup: count %0d leak %b floor %0d want 5 1 2", count, todo_leak_move, todo_leak_floor);
        end
        reset = 1'b0;
        leakage = 1'b0;
        leakage_floor = 3'd0;
        tick();
        n_checks++;
        if ({todo_exists, todo_in, todo_out, todo_leak_move, todo_license_plate, todo_leak_floor,
             count, full, req_error, overflow, drop_cnt} !== '0) begin
            n_fail++; $display("FAIL mid_reset: exists %b leak %b plate %h floor %0d count %0d ovf %b drop %0d want all 0",
                todo_exists, todo_leak_move, todo_license_plate, todo_leak_floor, count, overflow, drop_cnt);
        end
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_park();
        test_burst();
        test_invalid();
        test_overflow();
        test_leak_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_parking_request_queue
`default_nettype wire
